// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: one transmit shifter plus a one-entry receive buffer,
// read through a registered port with the same one-cycle latency as the memories.
module uart_mmio #(
    parameter int CPU_CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE      = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic        re,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        FPGA_SERIAL_RX,
    output logic        FPGA_SERIAL_TX
);
    localparam int SYMBOL_EDGE_TIME = CPU_CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int CNT_W            = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
    localparam logic [CNT_W-1:0] SYM_LAST    = CNT_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);

    typedef enum logic {TX_IDLE, TX_SHIFT} txState_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

    logic selected, wrTx, rdRx, rdAny;
    logic unusedBits;

    assign selected   = addr[31];
    assign rdAny      = selected & re;
    assign wrTx       = selected & we & (addr[3:2] == 2'b10);
    assign rdRx       = rdAny & (addr[3:2] == 2'b01);
    assign unusedBits = ^{addr[30:4], addr[1:0], wdata[31:8]};

    txState_t         txState_q, txState_d;
    logic [9:0]       txShift_q, txShift_d;
    logic [3:0]       txBit_q, txBit_d;
    logic [CNT_W-1:0] txCnt_q, txCnt_d;
    logic             txOut_q, txOut_d;
    logic             txReady, txStart, txSymEnd, txLastBit;

    assign txReady   = (txState_q == TX_IDLE);
    assign txStart   = wrTx & txReady;
    assign txSymEnd  = (txCnt_q == SYM_LAST);
    assign txLastBit = (txBit_q == 4'd9);
    assign FPGA_SERIAL_TX = txOut_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            txState_q <= TX_IDLE;
            txShift_q <= '0;
            txBit_q   <= '0;
            txCnt_q   <= '0;
            txOut_q   <= 1'b1;
        end else begin
            txState_q <= txState_d;
            txShift_q <= txShift_d;
            txBit_q   <= txBit_d;
            txCnt_q   <= txCnt_d;
            txOut_q   <= txOut_d;
        end
    end

    always_comb begin
        txState_d = txState_q;
        case (txState_q)
            TX_IDLE:  if (txStart) txState_d = TX_SHIFT;
            TX_SHIFT: if (txSymEnd && txLastBit) txState_d = TX_IDLE;
            default:  txState_d = TX_IDLE;
        endcase
    end

    // The line flop is loaded with the next bit on the same edge the bit period ends.
    always_comb begin
        txShift_d = txShift_q;
        txBit_d   = txBit_q;
        txCnt_d   = txCnt_q;
        txOut_d   = txOut_q;
        case (txState_q)
            TX_IDLE: begin
                txOut_d = 1'b1;
                if (txStart) begin
                    txShift_d = {1'b1, wdata[7:0], 1'b0};
                    txBit_d   = '0;
                    txCnt_d   = '0;
                    txOut_d   = 1'b0;
                end
            end
            TX_SHIFT: begin
                if (txSymEnd) begin
                    txCnt_d = '0;
                    if (txLastBit) begin
                        txOut_d = 1'b1;
                    end else begin
                        txBit_d   = txBit_q + 4'd1;
                        txShift_d = {1'b1, txShift_q[9:1]};
                        txOut_d   = txShift_q[1];
                    end
                end else begin
                    txCnt_d = txCnt_q + 1'b1;
                end
            end
            default: txOut_d = 1'b1;
        endcase
    end

    logic             rxSync1_q, rxSync2_q;
    rxState_t         rxState_q, rxState_d;
    logic [7:0]       rxShift_q, rxShift_d;
    logic [2:0]       rxBit_q, rxBit_d;
    logic [CNT_W-1:0] rxCnt_q, rxCnt_d;
    logic             rxAccept, rxSymEnd;
    logic [7:0]       rxByte_q;
    logic             rxValid_q, rxOverrun_q;

    assign rxSymEnd = (rxCnt_q == SYM_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxSync1_q <= 1'b1;
            rxSync2_q <= 1'b1;
            rxState_q <= RX_IDLE;
            rxShift_q <= '0;
            rxBit_q   <= '0;
            rxCnt_q   <= '0;
        end else begin
            rxSync1_q <= FPGA_SERIAL_RX;
            rxSync2_q <= rxSync1_q;
            rxState_q <= rxState_d;
            rxShift_q <= rxShift_d;
            rxBit_q   <= rxBit_d;
            rxCnt_q   <= rxCnt_d;
        end
    end

    // A start bit still low at half a symbol is genuine; otherwise it was a glitch.
    always_comb begin
        rxState_d = rxState_q;
        case (rxState_q)
            RX_IDLE:  if (!rxSync2_q) rxState_d = RX_START;
            RX_START: if (rxCnt_q == SAMPLE_LAST) rxState_d = rxSync2_q ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rxSymEnd && rxBit_q == 3'd7) rxState_d = RX_STOP;
            RX_STOP:  if (rxSymEnd) rxState_d = RX_IDLE;
            default:  rxState_d = RX_IDLE;
        endcase
    end

    always_comb begin
        rxShift_d = rxShift_q;
        rxBit_d   = rxBit_q;
        rxCnt_d   = rxCnt_q;
        rxAccept  = 1'b0;
        case (rxState_q)
            RX_IDLE: begin
                rxCnt_d = '0;
                rxBit_d = '0;
            end
            RX_START: rxCnt_d = (rxCnt_q == SAMPLE_LAST) ? '0 : rxCnt_q + 1'b1;
            RX_DATA: begin
                if (rxSymEnd) begin
                    rxCnt_d   = '0;
                    rxShift_d = {rxSync2_q, rxShift_q[7:1]};
                    rxBit_d   = rxBit_q + 3'd1;
                end else begin
                    rxCnt_d = rxCnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rxSymEnd) begin
                    rxCnt_d  = '0;
                    rxAccept = rxSync2_q;
                end else begin
                    rxCnt_d = rxCnt_q + 1'b1;
                end
            end
            default: rxCnt_d = '0;
        endcase
    end

    // A read of RXDATA on the accepting edge hands out the old byte and makes room for the new one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxByte_q    <= '0;
            rxValid_q   <= 1'b0;
            rxOverrun_q <= 1'b0;
        end else if (rxAccept) begin
            if (rdRx || !rxValid_q) begin
                rxByte_q    <= rxShift_q;
                rxValid_q   <= 1'b1;
                rxOverrun_q <= rdRx ? 1'b0 : rxOverrun_q;
            end else begin
                rxOverrun_q <= 1'b1;
            end
        end else if (rdRx) begin
            rxValid_q   <= 1'b0;
            rxOverrun_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (rdAny) begin
            case (addr[3:2])
                2'b00:   rdata <= {29'd0, rxOverrun_q, rxValid_q, txReady};
                2'b01:   rdata <= {24'd0, rxByte_q};
                default: rdata <= '0;
            endcase
        end
    end
endmodule
